// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store engine: op field layout,
// size codes, exception codes and the controller state encoding.
package mau_pkg;

  localparam int unsigned OP_STORE   = 3;
  localparam int unsigned OP_UNS     = 2;
  localparam int unsigned OP_SIZE_HI = 1;
  localparam int unsigned OP_SIZE_LO = 0;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_EXC
  } mau_state_e;

  // Natural alignment test on the three lowest address bits.
  function automatic logic is_misaligned(input logic [2:0] low_addr, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = low_addr[0];
      SZ_W:    bad = |low_addr[1:0];
      default: bad = |low_addr[2:0];
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_load_ext.sv
// Load data lane select and sign/zero extension for the response path.
module mau_load_ext
  import mau_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sbit;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    // A shift by the full width clears the vector, so oversize accesses keep everything.
    keep    = ~({DATA_W{1'b1}} << (8 << size));
    case (size)
      SZ_B:    sbit = shifted[7];
      SZ_H:    sbit = shifted[15];
      SZ_W:    sbit = shifted[31];
      default: sbit = shifted[DATA_W-1];
    endcase
    ext = shifted & keep;
    if (!uns && sbit) begin
      ext = ext | ~keep;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: aligns stores, runs a req/ack bus transaction
// and returns extended load data. Optional bus timeout under MAU_TIMEOUT_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic                  flush,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [4:0]            resp_exc,
  output logic [ADDR_W-1:0]     resp_badvaddr,
  output logic                  busy
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  mau_state_e        state;
  logic              st_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic              flushed_q;
  logic              resp_valid_q;

  logic              in_st;
  logic              in_uns;
  logic [1:0]        in_size;
  logic [OFF_W-1:0]  in_off;
  logic              in_bad;
  logic [BYTES-1:0]  be_calc;
  logic [DATA_W-1:0] ext_data;

  always_comb begin
    in_st   = req_op[OP_STORE];
    in_uns  = req_op[OP_UNS];
    in_size = req_op[OP_SIZE_HI:OP_SIZE_LO];
    in_off  = req_addr[OFF_W-1:0];
    in_bad  = is_misaligned(req_addr[2:0], in_size) || ((in_size == SZ_D) && (BYTES < 8));
    be_calc = ~({BYTES{1'b1}} << (1 << in_size)) << in_off;
  end

  mau_load_ext #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_ext (
    .rdata (bus_rdata),
    .off   (addr_q[OFF_W-1:0]),
    .size  (size_q),
    .uns   (uns_q),
    .ext   (ext_data)
  );

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE) || req_valid;
  // Response is registered on entry to RESP/EXC; a flush in that same cycle still kills it.
  assign resp_valid = resp_valid_q && !flush;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      st_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= SZ_B;
      addr_q        <= '0;
      flushed_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= '0;
      bus_wdata     <= '0;
      resp_rdata    <= '0;
      resp_exc      <= EXC_NONE;
      resp_badvaddr <= '0;
`ifdef MAU_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            st_q      <= in_st;
            uns_q     <= in_uns;
            size_q    <= in_size;
            addr_q    <= req_addr;
            flushed_q <= 1'b0;
            if (in_bad) begin
              state         <= ST_EXC;
              resp_valid_q  <= 1'b1;
              resp_rdata    <= '0;
              resp_exc      <= in_st ? EXC_ADES : EXC_ADEL;
              resp_badvaddr <= req_addr;
            end else begin
              state     <= ST_REQ;
              bus_req   <= 1'b1;
              bus_we    <= in_st;
              bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus_be    <= in_st ? be_calc : '1;
              bus_wdata <= in_st ? (req_wdata << {in_off, 3'b000}) : '0;
            end
          end
        end

        ST_REQ: begin
          if (bus_ack) begin
            state         <= ST_RESP;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_be        <= '0;
            bus_wdata     <= '0;
            resp_valid_q  <= !(flushed_q || flush);
            resp_rdata    <= st_q ? '0 : ext_data;
            resp_exc      <= EXC_NONE;
            resp_badvaddr <= '0;
`ifdef MAU_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end else begin
            flushed_q <= flushed_q || flush;
`ifdef MAU_TIMEOUT_EN
            if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
              state         <= ST_EXC;
              bus_req       <= 1'b0;
              bus_we        <= 1'b0;
              bus_addr      <= '0;
              bus_be        <= '0;
              bus_wdata     <= '0;
              resp_valid_q  <= !(flushed_q || flush);
              resp_rdata    <= '0;
              resp_exc      <= EXC_DBE;
              resp_badvaddr <= addr_q;
              tmo_cnt       <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
        end

        ST_RESP, ST_EXC: begin
          state         <= ST_IDLE;
          resp_valid_q  <= 1'b0;
          resp_rdata    <= '0;
          resp_exc      <= EXC_NONE;
          resp_badvaddr <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
